// File: rtl/layer_mem_arb_pkg.sv
// Shared definitions for the multi-channel layer memory arbiter:
// FSM state encodings and an index-width helper that never returns zero.
package layer_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } lmarb_state_e;

  // Width of an index into n items; a single item still needs one bit.
  function automatic int lmarb_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lmarb_rr_sel.sv
// Round-robin selector: picks the first requesting channel at or after ptr,
// scanning upward with wrap.
module lmarb_rr_sel
  import layer_mem_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  localparam int IDX_W = lmarb_clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic              valid,
  output logic [IDX_W-1:0]  idx
);

  localparam logic [IDX_W:0] NUM_CH_L = (IDX_W+1)'(NUM_CH);

  logic [2*NUM_CH-1:0] dbl;
  logic [NUM_CH-1:0]   rot;
  logic [IDX_W:0]      sum;

  // Rotating a doubled copy puts channel ptr at bit 0 of rot.
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[NUM_CH-1:0];

  always_comb begin
    valid = 1'b0;
    sum   = '0;
    // Descending scan so the smallest offset from ptr is the one that sticks.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        valid = 1'b1;
        sum   = {1'b0, ptr} + (IDX_W+1)'(i);
      end
    end
    if (sum >= NUM_CH_L) begin
      sum = sum - NUM_CH_L;
    end
    idx = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/layer_mem_arb.sv
// Round-robin arbiter of NUM_CH REQ/ACK channels onto one word-addressed memory,
// with programmable wait states and out-of-range error reporting.
module layer_mem_arb
  import layer_mem_arb_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0,
  localparam int IDX_W      = lmarb_clog2(NUM_CH)
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [NUM_CH-1:0]          REQ,
  input  logic [NUM_CH-1:0]          WRITE,
  input  logic [NUM_CH*ADDR_W-1:0]   ADDR,
  input  logic [NUM_CH*DATA_W-1:0]   DIN,
  output logic [NUM_CH-1:0]          ACK,
  output logic [DATA_W-1:0]          DOUT,
  output logic                       ERR,
  output logic [IDX_W-1:0]           GRANT_ID
);

  localparam int             MEM_AW  = lmarb_clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);

  lmarb_state_e        state_reg, state_next;
  logic [IDX_W-1:0]    ptr_reg, ptr_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic [IDX_W-1:0]    grant_reg, grant_next;
  logic                wr_reg, wr_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   din_reg, din_next;
  logic [NUM_CH-1:0]   ack_reg, ack_next;
  logic                err_reg, err_next;
  logic                rd_ok_reg, rd_ok_next;
  logic [DATA_W-1:0]   rd_reg;
  logic                do_access;
  logic                in_range;
  logic                sel_valid;
  logic [IDX_W-1:0]    sel_idx;
  logic [MEM_AW-1:0]   mem_idx;

  logic [ADDR_W-1:0]   ch_addr [NUM_CH];
  logic [DATA_W-1:0]   ch_din  [NUM_CH];
  logic [DATA_W-1:0]   mem     [DEPTH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign ch_addr[gi] = ADDR[gi*ADDR_W +: ADDR_W];
    assign ch_din[gi]  = DIN[gi*DATA_W +: DATA_W];
  end

  lmarb_rr_sel #(
    .NUM_CH (NUM_CH)
  ) u_rr_sel (
    .req   (REQ),
    .ptr   (ptr_reg),
    .valid (sel_valid),
    .idx   (sel_idx)
  );

  assign in_range = ({1'b0, addr_reg} < DEPTH_L);
  assign mem_idx  = addr_reg[MEM_AW-1:0];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      grant_reg <= '0;
      wr_reg    <= 1'b0;
      addr_reg  <= '0;
      din_reg   <= '0;
      ack_reg   <= '0;
      err_reg   <= 1'b0;
      rd_ok_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      grant_reg <= grant_next;
      wr_reg    <= wr_next;
      addr_reg  <= addr_next;
      din_reg   <= din_next;
      ack_reg   <= ack_next;
      err_reg   <= err_next;
      rd_ok_reg <= rd_ok_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (sel_valid) state_next = ACCESS;
      ACCESS:  if (cnt_reg == 4'd0) state_next = HOLD;
      HOLD:    if (!REQ[grant_reg]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    grant_next = grant_reg;
    wr_next    = wr_reg;
    addr_next  = addr_reg;
    din_next   = din_reg;
    ack_next   = ack_reg;
    err_next   = err_reg;
    rd_ok_next = rd_ok_reg;
    do_access  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sel_valid) begin
          grant_next = sel_idx;
          wr_next    = WRITE[sel_idx];
          addr_next  = ch_addr[sel_idx];
          din_next   = ch_din[sel_idx];
          cnt_next   = 4'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end else begin
          do_access = 1'b1;
          ack_next  = NUM_CH'(1) << grant_reg;
          err_next  = !in_range;
          // rd_ok gates DOUT: cleared on error, set on good read, kept on write.
          if (!in_range) begin
            rd_ok_next = 1'b0;
          end else if (!wr_reg) begin
            rd_ok_next = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!REQ[grant_reg]) begin
          ack_next = '0;
          err_next = 1'b0;
          ptr_next = (grant_reg == LAST_CH) ? '0 : grant_reg + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Memory has no reset; a reset on the completing edge suppresses the write.
  always_ff @(posedge CLK) begin
    if (!RESET && do_access && in_range) begin
      if (wr_reg) begin
        mem[mem_idx] <= din_reg;
      end else begin
        rd_reg <= mem[mem_idx];
      end
    end
  end

  assign ACK      = ack_reg;
  assign ERR      = err_reg;
  assign GRANT_ID = grant_reg;
  assign DOUT     = rd_ok_reg ? rd_reg : '0;

endmodule

// File: tb/tb_layer_mem_arb.sv
// Directed bench: three arbiter instances (no wait/DEPTH=200, 3 waits, 4 waits)
// driven by a transaction table and hand-written corner-case sequences.
module tb_layer_mem_arb;

  logic        clk;
  logic        rst_v  [3];
  logic [1:0]  req_v  [3];
  logic [1:0]  wr_v   [3];
  logic [15:0] addr_v [3];
  logic [63:0] din_v  [3];
  logic [1:0]  ack_v  [3];
  logic [31:0] dout_v [3];
  logic        err_v  [3];
  logic        gid_v  [3];

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  layer_mem_arb #(.NUM_CH(2), .ADDR_W(8), .DATA_W(32), .DEPTH(200), .WAIT_STATES(0)) dut0 (
    .CLK(clk), .RESET(rst_v[0]), .REQ(req_v[0]), .WRITE(wr_v[0]), .ADDR(addr_v[0]),
    .DIN(din_v[0]), .ACK(ack_v[0]), .DOUT(dout_v[0]), .ERR(err_v[0]), .GRANT_ID(gid_v[0]));

  layer_mem_arb #(.NUM_CH(2), .ADDR_W(8), .DATA_W(32), .DEPTH(256), .WAIT_STATES(3)) dut1 (
    .CLK(clk), .RESET(rst_v[1]), .REQ(req_v[1]), .WRITE(wr_v[1]), .ADDR(addr_v[1]),
    .DIN(din_v[1]), .ACK(ack_v[1]), .DOUT(dout_v[1]), .ERR(err_v[1]), .GRANT_ID(gid_v[1]));

  layer_mem_arb #(.NUM_CH(2), .ADDR_W(8), .DATA_W(32), .DEPTH(256), .WAIT_STATES(4)) dut2 (
    .CLK(clk), .RESET(rst_v[2]), .REQ(req_v[2]), .WRITE(wr_v[2]), .ADDR(addr_v[2]),
    .DIN(din_v[2]), .ACK(ack_v[2]), .DOUT(dout_v[2]), .ERR(err_v[2]), .GRANT_ID(gid_v[2]));

  typedef struct {
    int          ch;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] din;
    logic [31:0] exp_dout;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int d, input int ch, input logic w, input logic [7:0] a,
                        input logic [31:0] din);
    wr_v[d][ch]          = w;
    addr_v[d][ch*8 +: 8] = a;
    din_v[d][ch*32 +: 32] = din;
    req_v[d][ch]         = 1'b1;
  endtask

  // Waits for ACK, checks the completion, holds REQ 'hold' extra cycles, then releases.
  task automatic wait_ack(input int d, input int ch, input int exp_lat,
                          input logic [31:0] exp_dout, input logic exp_err, input int hold);
    int lat = 0;
    logic [1:0]  exp_ack;
    logic [31:0] got_dout;
    exp_ack = 2'b01 << ch;
    while (ack_v[d] == 2'b00 && lat < 40) begin
      tick();
      lat++;
    end
    if (exp_lat >= 0) chk("latency", lat, exp_lat);
    chk("ack_onehot", ack_v[d], exp_ack);
    chk("grant_id", gid_v[d], ch);
    chk("dout", dout_v[d], exp_dout);
    chk("err", err_v[d], exp_err);
    got_dout = dout_v[d];
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("ack_hold", ack_v[d], exp_ack);
      chk("dout_hold", dout_v[d], exp_dout);
    end
    req_v[d][ch] = 1'b0;
    tick();
    chk("ack_release", ack_v[d], 2'b00);
    chk("err_release", err_v[d], 1'b0);
    $display("xfer dut=%0d ch=%0d lat=%0d dout=%08h err=%0b", d, ch, lat, got_dout, exp_err);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_v[d]  = 1'b1;
      req_v[d]  = '0;
      wr_v[d]   = '0;
      addr_v[d] = '0;
      din_v[d]  = '0;
    end
    vecs[0] = '{0, 1'b1, 8'h10, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[1] = '{0, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2] = '{1, 1'b1, 8'd50, 32'hA5A50032, 32'hDEADBEEF, 1'b0};
    vecs[3] = '{1, 1'b1, 8'd199, 32'h0000C7C7, 32'hDEADBEEF, 1'b0};
    vecs[4] = '{1, 1'b0, 8'd199, 32'h0,       32'h0000C7C7, 1'b0};
    vecs[5] = '{1, 1'b1, 8'd250, 32'hBAD0BAD0, 32'h00000000, 1'b1};
    vecs[6] = '{0, 1'b0, 8'd250, 32'h0,       32'h00000000, 1'b1};
    vecs[7] = '{0, 1'b1, 8'd200, 32'h11111111, 32'h00000000, 1'b1};
    vecs[8] = '{0, 1'b0, 8'd50, 32'h0,        32'hA5A50032, 1'b0};
    vecs[9] = '{1, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0};

    tick();
    tick();
    for (int d = 0; d < 3; d++) rst_v[d] = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk("rst_ack", ack_v[d], 2'b00);
      chk("rst_dout", dout_v[d], 32'h0);
      chk("rst_err", err_v[d], 1'b0);
      chk("rst_gid", gid_v[d], 1'b0);
    end

    // Table of single-channel transfers on the zero-wait, DEPTH=200 instance.
    for (int i = 0; i < 10; i++) begin
      set_ch(0, vecs[i].ch, vecs[i].wr, vecs[i].addr, vecs[i].din);
      wait_ack(0, vecs[i].ch, 2, vecs[i].exp_dout, vecs[i].exp_err, (i == 1) ? 2 : 0);
    end

    // Contention straight out of reset: grants alternate 0,1,0,1.
    rst_v[0] = 1'b1;
    tick();
    rst_v[0] = 1'b0;
    set_ch(0, 0, 1'b0, 8'h10, 32'h0);
    set_ch(0, 1, 1'b0, 8'd50, 32'h0);
    for (int n = 0; n < 4; n++) begin
      wait_ack(0, n % 2, 2, (n % 2 == 0) ? 32'hDEADBEEF : 32'hA5A50032, 1'b0, 0);
      set_ch(0, n % 2, 1'b0, (n % 2 == 0) ? 8'h10 : 8'd50, 32'h0);
    end
    req_v[0] = 2'b00;
    tick();

    // Early REQ drop on ch1 with pointer at 1; pointer must then return to 0.
    set_ch(0, 0, 1'b0, 8'h10, 32'h0);
    wait_ack(0, 0, 2, 32'hDEADBEEF, 1'b0, 0);
    set_ch(0, 1, 1'b0, 8'd50, 32'h0);
    tick();
    req_v[0][1] = 1'b0;
    tick();
    chk("early_ack", ack_v[0], 2'b10);
    chk("early_dout", dout_v[0], 32'hA5A50032);
    tick();
    chk("early_ack_pulse", ack_v[0], 2'b00);
    $display("xfer dut=0 ch=1 early drop dout=%08h", 32'hA5A50032);
    set_ch(0, 0, 1'b0, 8'h10, 32'h0);
    set_ch(0, 1, 1'b0, 8'd50, 32'h0);
    wait_ack(0, 0, 2, 32'hDEADBEEF, 1'b0, 0);
    wait_ack(0, 1, 2, 32'hA5A50032, 1'b0, 0);

    // Three wait states: latency 5, DOUT stable while REQ is held.
    set_ch(1, 0, 1'b1, 8'd5, 32'hCAFE0005);
    wait_ack(1, 0, 5, 32'h0, 1'b0, 0);
    set_ch(1, 1, 1'b0, 8'd5, 32'h0);
    wait_ack(1, 1, 5, 32'hCAFE0005, 1'b0, 4);

    // Reset while a write to addr 3 is still counting wait states.
    set_ch(2, 0, 1'b1, 8'd3, 32'h33333333);
    wait_ack(2, 0, 6, 32'h0, 1'b0, 0);
    set_ch(2, 1, 1'b1, 8'd3, 32'h99999999);
    tick();
    tick();
    chk("mid_gid", gid_v[2], 1'b1);
    rst_v[2] = 1'b1;
    tick();
    rst_v[2] = 1'b0;
    chk("mid_rst_ack", ack_v[2], 2'b00);
    chk("mid_rst_gid", gid_v[2], 1'b0);
    chk("mid_rst_dout", dout_v[2], 32'h0);
    set_ch(2, 0, 1'b0, 8'd3, 32'h0);
    set_ch(2, 1, 1'b0, 8'd3, 32'h0);
    wait_ack(2, 0, 6, 32'h33333333, 1'b0, 0);
    wait_ack(2, 1, 6, 32'h33333333, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/layer_mem_arb.md
Name: layer_mem_arb

Overview:
- Parametrised successor to the single-master layer memory path.
- Arbitrates NUM_CH independent requesters onto one internal word-addressed memory. Requesters are layer-controller channels, e.g. an MBus RX handler and a local sensor DMA.
- Each channel uses the existing 4-phase REQ/ACK memory handshake.
- Adds round-robin fairness, configurable wait states and out-of-range error reporting, none of which the previous memory path had.

Parameters:
- NUM_CH, 2, number of requesting channels (1..8).
- ADDR_W, 8, word-address width per channel.
- DATA_W, 32, data word width.
- DEPTH, 256, number of memory words; must satisfy DEPTH <= 2**ADDR_W.
- WAIT_STATES, 0, extra cycles inserted before each access completes (0..15).

Ports:
- CLK  in  1  clock; all logic is on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- REQ  in  NUM_CH  per-channel request level.
- WRITE  in  NUM_CH  per-channel access type; 1 = write, 0 = read. Valid while REQ is high.
- ADDR  in  NUM_CH*ADDR_W  per-channel word address; channel i occupies [i*ADDR_W +: ADDR_W].
- DIN  in  NUM_CH*DATA_W  per-channel write data; channel i occupies [i*DATA_W +: DATA_W].
- ACK  out  NUM_CH  per-channel acknowledge; one-hot or zero.
- DOUT  out  DATA_W  read data; valid while any ACK bit is high.
- ERR  out  1  access error flag; valid while any ACK bit is high.
- GRANT_ID  out  clog2(NUM_CH) (min 1)  channel currently granted; debug only.

Behaviour:
- Reset: the synchronous active-high reset takes effect at the clock edge where RESET=1. It forces:
  - ACK=0, DOUT=0, ERR=0, GRANT_ID=0
  - state=IDLE, round-robin pointer=0, wait counter=0
  - memory contents are not reset.
- Reset mid-operation: the access is abandoned and ACK drops at that edge. A write is abandoned only if it has not yet been committed in ACCESS.
- IDLE:
  - If any REQ bit is high, grant the first requesting channel at or after the pointer, in ascending index order with wrap.
  - Latch that channel's WRITE, ADDR and DIN. Set GRANT_ID, load the counter with WAIT_STATES, go to ACCESS.
  - If no REQ bit is high, stay in IDLE.
- ACCESS:
  - While the counter is nonzero, decrement it.
  - When the counter is zero, perform the access, assert ACK[grant]=1 and go to HOLD.
  - Write: mem[addr] <= din; DOUT is unchanged; ERR=0.
  - Read: DOUT <= mem[addr]; ERR=0.
  - Address >= DEPTH: no write, DOUT <= 0, ERR=1.
- Latency: REQ first sampled high at edge k gives ACK high after edge k+1+WAIT_STATES. With WAIT_STATES=0 this is 2 cycles.
- HOLD:
  - Hold ACK, DOUT and ERR stable while REQ[grant] stays high.
  - When REQ[grant] is sampled low, set ACK=0 and ERR=0, set pointer=(grant+1) mod NUM_CH, and go to IDLE.
  - DOUT holds its last value.
- Back-to-back: the minimum REQ-high to next grant spacing is one IDLE cycle after ACK falls.
- Simultaneous requests: exactly one channel is granted. The channels not granted keep their REQ high, and each is guaranteed service within NUM_CH grants.
- REQ dropped before ACK (protocol violation): the access still completes. ACK pulses for exactly one cycle in HOLD.
- Other channels' REQ, ADDR and DIN changes during ACCESS or HOLD are ignored.
- NUM_CH=1: the pointer stays at 0 and behaviour degenerates to a single-master controller.

Decomposition:
- Shared include (alongside the MBus definitions): state encodings IDLE/ACCESS/HOLD, and a clog2 helper macro for GRANT_ID and pointer widths.
- Sub-module lmarb_rr_sel: purely combinational. Inputs are REQ and the pointer; outputs are a valid flag and the granted index. It is instantiated once.
- Memory is a behavioural reg array inside layer_mem_arb, so it can later be swapped for an SRAM macro.

Test Plan:
- Single write then read, NUM_CH=2, WAIT_STATES=0: ch0 writes 0xDEADBEEF to addr 0x10; ch0 then reads 0x10. Required: DOUT=0xDEADBEEF, ERR=0, ACK[0] high 2 cycles after REQ.
- Simultaneous contention: REQ=2'b11 held continuously out of reset. Grants must alternate 0,1,0,1 with ACK never two-hot; 4 accesses complete with pointer wrap.
- Wait states, WAIT_STATES=3: a read of addr 5 gives ACK exactly 5 cycles after REQ is first sampled; DOUT is stable until REQ drops.
- Out of range, DEPTH=200: a write to addr 250 gives ERR=1 with ACK; a subsequent read of addr 250 gives DOUT=0, ERR=1; mem[250 mod 256 alias] is unchanged.
- Reset mid-access, WAIT_STATES=4: assert RESET during ACCESS for a write to addr 3. ACK=0 at the next edge, state is IDLE, mem[3] keeps its old value, and a post-reset grant starts at ch0.
- Early REQ drop: ch1 drops REQ one cycle after request. The access still completes, ACK[1] is high for exactly 1 cycle, and the pointer advances to 0.
